ram_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer for the single-port RAM (wen/addr/bidirectional data).
- Serialises read and write transactions from two masters onto the shared RAM bus.
- Owns tri-state control of the data bus so the RAM and the arbiter never drive it at the same time.
- Sits between the two datapath masters and one RAM instance, with RAM rst_n tied to the same rst_n.

---
 rtl/ram_arbiter.sv | 137 +++++++++++++
 tb/tb_ram_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a single-port RAM (wen/addr/shared data bus).
// Optional grant counters are enabled with `define RAM_ARB_STATS_EN.
module ram_arbiter #(
  parameter int addr_width = 4,
  parameter int data_width = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [addr_width-1:0] addr0,
  input  logic [data_width-1:0] wdata0,
  output logic                  ack0,
  output logic [data_width-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [addr_width-1:0] addr1,
  input  logic [data_width-1:0] wdata1,
  output logic                  ack1,
  output logic [data_width-1:0] rdata1,
  output logic                  ram_wen,
  output logic [addr_width-1:0] ram_addr,
  inout  wire  [data_width-1:0] ram_data
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [7:0]            gnt_cnt0,
  output logic [7:0]            gnt_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_e;

  state_e                state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic                  last_q, last_d;
  logic                  we_q, we_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [data_width-1:0] wdata_q, wdata_d;
  logic [data_width-1:0] rdata0_q, rdata0_d;
  logic [data_width-1:0] rdata1_q, rdata1_d;
  logic                  winner;
  logic                  ram_oe;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    winner   = 1'b0;
    ack0     = 1'b0;
    ack1     = 1'b0;
    ram_wen  = 1'b0;
    ram_oe   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that did not win last time gets the bus.
          winner  = (req0 && req1) ? ~last_q : req1;
          gnt_d   = winner;
          last_d  = winner;
          we_d    = winner ? we1    : we0;
          addr_d  = winner ? addr1  : addr0;
          wdata_d = winner ? wdata1 : wdata0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        ram_wen = we_q;
        ram_oe  = we_q;
        if (!we_q) begin
          if (gnt_q) rdata1_d = ram_data;
          else       rdata0_d = ram_data;
        end
        state_d = ACK;
      end
      ACK: begin
        ack0    = ~gnt_q;
        ack1    = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // The bus is only driven in a write BUSY cycle, exactly when ram_wen is high,
  // and releases as soon as reset asserts since ram_oe decodes the reset state.
  assign ram_data = ram_oe ? wdata_q : {data_width{1'bz}};
  assign ram_addr = addr_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;

`ifdef RAM_ARB_STATS_EN
  logic [7:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (state_q == ACK) begin
      if (!gnt_q && cnt0_q != 8'hFF) cnt0_q <= cnt0_q + 8'd1;
      if ( gnt_q && cnt1_q != 8'hFF) cnt1_q <= cnt1_q + 8'd1;
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural single-port RAM on the shared bus.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [3:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic       ack0, ack1, ram_wen;
  logic [3:0] rdata0, rdata1, ram_addr;
  wire  [3:0] ram_data;
`ifdef RAM_ARB_STATS_EN
  logic [7:0] gnt_cnt0, gnt_cnt1;
`endif

  int checks = 0;
  int errors = 0;
  logic [3:0] rd_m [2];
  logic       lg;

  always #5 clk = ~clk;

  ram_arbiter #(.addr_width(4), .data_width(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_data(ram_data)
`ifdef RAM_ARB_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );

  // Single-port RAM model: drives the bus whenever it is not being written.
  logic [3:0] mem [16];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (ram_wen) begin
      mem[ram_addr] <= ram_data;
    end
  end
  assign ram_data = ram_wen ? 4'bzzzz : mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus safety on every cycle, away from the active edge.
  always @(negedge clk) begin
    check("bus_oe_without_wen", {31'd0, (!ram_wen && dut.ram_oe)}, 32'd0);
    if (!ram_wen) check("bus_x_on_read", {31'd0, $isunknown(ram_data)}, 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit p, input bit v, input bit we, input logic [3:0] a, input logic [3:0] d);
    if (p) begin req1 = v; we1 = we; addr1 = a; wdata1 = d; end
    else   begin req0 = v; we0 = we; addr0 = a; wdata0 = d; end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    rd_m[0] = '0;
    rd_m[1] = '0;
    lg = 1'b1;
  endtask

  // One isolated transaction; expects BUSY after the first edge and ACK after the second.
  task automatic txn(input bit p, input bit we, input logic [3:0] a, input logic [3:0] d,
                     input logic [3:0] exp_rd, input string tag);
    set_req(p, 1'b1, we, a, d);
    tick();
    check({tag, "_busy_wen"}, {31'd0, ram_wen}, {31'd0, we});
    check({tag, "_busy_addr"}, {28'd0, ram_addr}, {28'd0, a});
    if (we) check({tag, "_busy_data"}, {28'd0, ram_data}, {28'd0, d});
    check({tag, "_busy_acks"}, {30'd0, ack1, ack0}, 32'd0);
    tick();
    check({tag, "_ack"}, {30'd0, ack1, ack0}, p ? 32'd2 : 32'd1);
    if (!we) rd_m[p] = exp_rd;
    check({tag, "_rdata0"}, {28'd0, rdata0}, {28'd0, rd_m[0]});
    check({tag, "_rdata1"}, {28'd0, rdata1}, {28'd0, rd_m[1]});
    check({tag, "_ack_wen"}, {31'd0, ram_wen}, 32'd0);
    set_req(p, 1'b0, 1'b0, '0, '0);
    lg = p;
    tick();
    check({tag, "_idle_acks"}, {30'd0, ack1, ack0}, 32'd0);
  endtask

  initial begin
    rd_m[0] = '0;
    rd_m[1] = '0;
    lg = 1'b1;
    #2;
    // Reset values.
    check("rst_ack", {30'd0, ack1, ack0}, 32'd0);
    check("rst_rdata", {24'd0, rdata1, rdata0}, 32'd0);
    check("rst_wen", {31'd0, ram_wen}, 32'd0);
    check("rst_addr", {28'd0, ram_addr}, 32'd0);
    check("rst_oe", {31'd0, dut.ram_oe}, 32'd0);
    tick();
    rst_n = 1'b1;

    // Write then read from a single requester.
    txn(1'b0, 1'b1, 4'd2, 4'hA, 4'h0, "w0_a2");
    txn(1'b0, 1'b0, 4'd2, 4'h0, 4'hA, "r0_a2");

    // Simultaneous writes straight after reset: requester 0 first.
    apply_reset();
    set_req(1'b0, 1'b1, 1'b1, 4'd1, 4'h5);
    set_req(1'b1, 1'b1, 1'b1, 4'd3, 4'hC);
    tick();
    check("sim_busy0_addr", {28'd0, ram_addr}, 32'd1);
    check("sim_busy0_data", {28'd0, ram_data}, 32'h5);
    check("sim_busy0_wen", {31'd0, ram_wen}, 32'd1);
    tick();
    check("sim_ack0", {30'd0, ack1, ack0}, 32'd1);
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    check("sim_idle", {30'd0, ack1, ack0}, 32'd0);
    tick();
    check("sim_busy1_addr", {28'd0, ram_addr}, 32'd3);
    check("sim_busy1_data", {28'd0, ram_data}, 32'hC);
    tick();
    check("sim_ack1", {30'd0, ack1, ack0}, 32'd2);
    check("sim_write_keeps_rdata", {24'd0, rdata1, rdata0}, 32'd0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    tick();
    lg = 1'b1;
    txn(1'b0, 1'b0, 4'd1, 4'h0, 4'h5, "r0_a1");
    txn(1'b1, 1'b0, 4'd3, 4'h0, 4'hC, "r1_a3");

    // Continuous contention: six reads, grants must alternate starting with requester 0.
    set_req(1'b0, 1'b1, 1'b0, 4'd1, 4'h0);
    set_req(1'b1, 1'b1, 1'b0, 4'd3, 4'h0);
    for (int k = 0; k < 6; k++) begin
      automatic logic w = ~lg;
      tick();
      check($sformatf("cont%0d_addr", k), {28'd0, ram_addr}, w ? 32'd3 : 32'd1);
      tick();
      check($sformatf("cont%0d_ack", k), {30'd0, ack1, ack0}, w ? 32'd2 : 32'd1);
      check($sformatf("cont%0d_rdata", k), {24'd0, rdata1, rdata0}, 32'hC5);
      if (k == 5) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      lg = w;
      tick();
      check($sformatf("cont%0d_idle", k), {30'd0, ack1, ack0}, 32'd0);
    end

    // Random traffic; the negedge monitor checks bus safety throughout.
    for (int k = 0; k < 60; k++) begin
      req0 = 1'($urandom_range(0, 1)); we0 = 1'($urandom_range(0, 1));
      addr0 = 4'($urandom_range(0, 15)); wdata0 = 4'($urandom_range(0, 15));
      req1 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
      addr1 = 4'($urandom_range(0, 15)); wdata1 = 4'($urandom_range(0, 15));
      tick();
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick(); tick(); tick();
    check("rand_settle_acks", {30'd0, ack1, ack0}, 32'd0);

    // Reset during the BUSY cycle of a write to address 0.
    set_req(1'b0, 1'b1, 1'b1, 4'd0, 4'h9);
    tick();
    check("mid_busy_wen", {31'd0, ram_wen}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wen", {31'd0, ram_wen}, 32'd0);
    check("mid_rst_oe", {31'd0, dut.ram_oe}, 32'd0);
    check("mid_rst_acks", {30'd0, ack1, ack0}, 32'd0);
    check("mid_rst_rdata", {24'd0, rdata1, rdata0}, 32'd0);
    req0 = 1'b0;
    tick();
    tick();
    check("mid_rst_noack", {30'd0, ack1, ack0}, 32'd0);
    rst_n = 1'b1;
    set_req(1'b1, 1'b1, 1'b0, 4'd3, 4'h0);
    set_req(1'b0, 1'b1, 1'b0, 4'd1, 4'h0);
    tick();
    check("post_rst_addr", {28'd0, ram_addr}, 32'd1);
    tick();
    check("post_rst_ack0", {30'd0, ack1, ack0}, 32'd1);
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    check("post_rst_addr1", {28'd0, ram_addr}, 32'd3);
    tick();
    check("post_rst_ack1", {30'd0, ack1, ack0}, 32'd2);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    tick();

`ifdef RAM_ARB_STATS_EN
    apply_reset();
    check("stats_rst", {16'd0, gnt_cnt1, gnt_cnt0}, 32'd0);
    for (int k = 0; k < 300; k++) txn(1'b0, 1'b0, 4'd0, 4'h0, 4'h0, "st_r0");
    txn(1'b1, 1'b1, 4'd4, 4'h7, 4'h0, "st_w1a");
    txn(1'b1, 1'b1, 4'd5, 4'h8, 4'h0, "st_w1b");
    check("stats_cnt0_sat", {24'd0, gnt_cnt0}, 32'd255);
    check("stats_cnt1", {24'd0, gnt_cnt1}, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
